bin2gray_counter: RTL and testbench

Parameterized binary counter with a registered Gray-code output, the encode-side counterpart of the team's Gray-to-binary converter. It produces a Gray-coded count in which exactly one bit changes per step, so the count can safely cross into another clock domain. The receiving domain synchronizes the Gray value and decodes it back to binary. It serves as the pointer and phase-count source in the PLL clock-crossing paths.

---
 rtl/bin2gray_counter_if.sv | 24 ++
 rtl/bin2gray_counter.sv | 53 +++++
 tb/tb_bin2gray_counter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2gray_counter_if.sv
// Control and count bundle for bin2gray_counter.
// master drives the controls; slave returns the registered count.
interface bin2gray_counter_if #(
   parameter int SIZE = 4
);
   logic            enable;
   logic            up_down;
   logic            load;
   logic [SIZE-1:0] load_bin;
   logic [SIZE-1:0] bin;
   logic [SIZE-1:0] gray;
   logic            wrap;
   logic            multi_bit;

   modport master (
      output enable, up_down, load, load_bin,
      input  bin, gray, wrap, multi_bit
   );

   modport slave (
      input  enable, up_down, load, load_bin,
      output bin, gray, wrap, multi_bit
   );
endinterface

// File: rtl/bin2gray_counter.sv
// Up/down binary counter with registered Gray output for CDC pointers.
// wrap and multi_bit are one-cycle pulses following a wrap or a load.
module bin2gray_counter #(
   parameter int SIZE = 4
) (
   input  logic             clk,
   input  logic             reset,
   bin2gray_counter_if.slave bus
);
   localparam logic [SIZE-1:0] ONE = SIZE'(1);

   logic [SIZE-1:0] bin_q, bin_d;
   logic [SIZE-1:0] gray_q, gray_d;
   logic            wrap_q, wrap_d;
   logic            mb_q, mb_d;

   // Carry out of +1 is all-ones; borrow out of -1 is all-zeros.
   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      mb_d   = 1'b0;
      if (bus.load) begin
         bin_d = bus.load_bin;
         mb_d  = 1'b1;
      end else if (bus.enable && bus.up_down) begin
         bin_d  = bin_q + ONE;
         wrap_d = &bin_q;
      end else if (bus.enable) begin
         bin_d  = bin_q - ONE;
         wrap_d = ~|bin_q;
      end
      gray_d = bin_d ^ (bin_d >> 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
         mb_q   <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
         mb_q   <= mb_d;
      end
   end

   assign bus.bin       = bin_q;
   assign bus.gray      = gray_q;
   assign bus.wrap      = wrap_q;
   assign bus.multi_bit = mb_q;
endmodule

// File: tb/tb_bin2gray_counter.sv
// Directed and model-based checks of bin2gray_counter at SIZE=4 and SIZE=7.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_bin2gray_counter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   failed = 0;

   bin2gray_counter_if #(.SIZE(4)) b4 ();
   bin2gray_counter_if #(.SIZE(7)) b7 ();

   bin2gray_counter #(.SIZE(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (b4)
   );

   bin2gray_counter #(.SIZE(7)) dut7 (
      .clk   (clk),
      .reset (reset),
      .bus   (b7)
   );

   always #5 clk = ~clk;

   logic [3:0] gseq [17] = '{
      4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
      4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0
   };

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive4(input logic en, input logic ud,
                         input logic ld, input logic [3:0] lb);
      b4.enable   = en;
      b4.up_down  = ud;
      b4.load     = ld;
      b4.load_bin = lb;
   endtask

   task automatic chk4(input string tag, input logic [3:0] eb,
                       input logic [3:0] eg, input logic ew,
                       input logic em);
      check({tag, ".bin"},  32'(b4.bin),       32'(eb));
      check({tag, ".gray"}, 32'(b4.gray),      32'(eg));
      check({tag, ".wrap"}, 32'(b4.wrap),      32'(ew));
      check({tag, ".mb"},   32'(b4.multi_bit), 32'(em));
   endtask

   // Independent reference: next count, wrap and load flag for width sz.
   task automatic model(input int sz, input logic en, input logic ud,
                        input logic ld, input logic [31:0] lb,
                        inout logic [31:0] b,
                        output logic w, output logic m);
      logic [31:0] mask;
      mask = (32'd1 << sz) - 32'd1;
      w = 1'b0;
      m = ld;
      if (ld) begin
         b = lb & mask;
      end else if (en && ud) begin
         w = (b == mask);
         b = (b + 32'd1) & mask;
      end else if (en) begin
         w = (b == 32'd0);
         b = (b - 32'd1) & mask;
      end
   endtask

   initial begin
      logic [31:0] m4b, m7b, r;
      logic        w4, w7, mm4, mm7, en, ud, ld;
      logic [3:0]  pg4;
      logic [6:0]  pg7;

      drive4(1'b0, 1'b1, 1'b0, 4'h0);
      b7.enable   = 1'b0;
      b7.up_down  = 1'b0;
      b7.load     = 1'b0;
      b7.load_bin = '0;
      #2;
      chk4("rst", 4'h0, 4'h0, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b0;

      // Full up count from reset
      drive4(1'b1, 1'b1, 1'b0, 4'h0);
      for (int i = 1; i <= 16; i++) begin
         pg4 = b4.gray;
         step();
         chk4($sformatf("up%0d", i), 4'(i), gseq[i], i == 16, 1'b0);
         check($sformatf("up%0d.ham", i), 32'($countones(pg4 ^ b4.gray)), 32'd1);
      end
      for (int i = 0; i < 9; i++) step();
      chk4("at9", 4'h9, 4'hD, 1'b0, 1'b0);

      // Asynchronous reset mid-count, no edge needed
      #2;
      reset = 1'b1;
      #1;
      chk4("arst", 4'h0, 4'h0, 1'b0, 1'b0);
      step();
      chk4("arst_hold", 4'h0, 4'h0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;

      // Down wrap
      drive4(1'b1, 1'b0, 1'b0, 4'h0);
      step();
      chk4("dn_wrap", 4'hF, 4'h8, 1'b1, 1'b0);
      step();
      chk4("dn_next", 4'hE, 4'h9, 1'b0, 1'b0);

      // Load beats enable
      reset = 1'b1;
      #1;
      reset = 1'b0;
      drive4(1'b1, 1'b1, 1'b0, 4'h0);
      step();
      step();
      step();
      chk4("at3", 4'h3, 4'h2, 1'b0, 1'b0);
      drive4(1'b1, 1'b1, 1'b1, 4'hA);
      step();
      chk4("ld_pri", 4'hA, 4'hF, 1'b0, 1'b1);
      drive4(1'b1, 1'b1, 1'b0, 4'h0);
      step();
      chk4("ld_after", 4'hB, 4'hE, 1'b0, 1'b0);

      // Hold
      drive4(1'b0, 1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk4($sformatf("hold%0d", i), 4'hB, 4'hE, 1'b0, 1'b0);
      end

      // Loads of max, same value and zero never wrap
      drive4(1'b1, 1'b1, 1'b1, 4'hF);
      step();
      chk4("ld_max", 4'hF, 4'h8, 1'b0, 1'b1);
      step();
      chk4("ld_same", 4'hF, 4'h8, 1'b0, 1'b1);
      drive4(1'b1, 1'b0, 1'b1, 4'h0);
      step();
      chk4("ld_zero", 4'h0, 4'h0, 1'b0, 1'b1);
      drive4(1'b0, 1'b0, 1'b0, 4'h0);
      step();
      chk4("ld_clr", 4'h0, 4'h0, 1'b0, 1'b0);

      // Random stimulus against the reference model, both widths
      reset = 1'b1;
      #1;
      reset = 1'b0;
      m4b = '0;
      m7b = '0;
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         ud = 1'($urandom_range(0, 1));
         ld = ($urandom_range(0, 7) == 0);
         r  = $urandom;
         drive4(en, ud, ld, r[3:0]);
         b7.enable   = en;
         b7.up_down  = ud;
         b7.load     = ld;
         b7.load_bin = r[6:0];
         pg4 = b4.gray;
         pg7 = b7.gray;
         model(4, en, ud, ld, r, m4b, w4, mm4);
         model(7, en, ud, ld, r, m7b, w7, mm7);
         step();
         check("r4.bin",  32'(b4.bin),       m4b);
         check("r4.gray", 32'(b4.gray),      m4b ^ (m4b >> 1));
         check("r4.wrap", 32'(b4.wrap),      32'(w4));
         check("r4.mb",   32'(b4.multi_bit), 32'(mm4));
         check("r7.bin",  32'(b7.bin),       m7b);
         check("r7.gray", 32'(b7.gray),      m7b ^ (m7b >> 1));
         check("r7.wrap", 32'(b7.wrap),      32'(w7));
         check("r7.mb",   32'(b7.multi_bit), 32'(mm7));
         if (en && !ld) begin
            check("r4.ham", 32'($countones(pg4 ^ b4.gray)), 32'd1);
            check("r7.ham", 32'($countones(pg7 ^ b7.gray)), 32'd1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
